// File: rtl/sd_frame_fetch.sv
// Fetches one frame from an SD controller, sector by sector, and packs the
// byte stream big-endian into 32-bit frame-buffer writes.
module sd_frame_fetch #(
    parameter int unsigned WORDS        = 19200,
    parameter int unsigned SECTOR_BYTES = 512,
    parameter int unsigned ADDR_W       = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       base_addr,
    output logic              busy,
    output logic              done,
    output logic              sd_rd,
    output logic [31:0]       sd_address,
    input  logic              sd_ready_for_read,
    input  logic [7:0]        sd_byte,
    input  logic              sd_byte_available,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data
);

    localparam int unsigned      CNT_W       = ADDR_W + 1;
    localparam int unsigned      SEC_W       = $clog2(SECTOR_BYTES + 1);
    localparam logic [CNT_W-1:0] WORDS_C     = CNT_W'(WORDS);
    localparam logic [SEC_W-1:0] LAST_BYTE   = SEC_W'(SECTOR_BYTES - 1);
    localparam logic [31:0]      SECTOR_STEP = 32'(SECTOR_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_ISSUE,
        S_RECV,
        S_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        base_q, base_d;
    logic [31:0]        sector_idx_q, sector_idx_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [SEC_W-1:0]   sec_byte_q, sec_byte_d;
    logic [23:0]        shift_q, shift_d;
    logic               avail_q;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sd_rd_q, sd_rd_d;
    logic [31:0]        sd_address_q, sd_address_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;

    logic rx_evt_c;
    logic word_wr_c;
    logic sector_end_c;
    logic frame_more_c;

    // Byte events count only in RECV; the word limit gates writes, not consumption.
    assign rx_evt_c     = sd_byte_available && !avail_q && (state_q == S_RECV);
    assign word_wr_c    = rx_evt_c && (byte_idx_q == 2'd3) && (word_cnt_q < WORDS_C);
    assign sector_end_c = rx_evt_c && (sec_byte_q == LAST_BYTE);
    assign frame_more_c = (word_cnt_q + CNT_W'(word_wr_c)) < WORDS_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (start) state_d = S_WAIT_RDY;
            S_WAIT_RDY: if (sd_ready_for_read) state_d = S_ISSUE;
            S_ISSUE:    if (!sd_ready_for_read) state_d = S_RECV;
            S_RECV:     if (sector_end_c) state_d = frame_more_c ? S_WAIT_RDY : S_FIN;
            S_FIN:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        base_d       = base_q;
        sector_idx_d = sector_idx_q;
        word_cnt_d   = word_cnt_q;
        byte_idx_d   = byte_idx_q;
        sec_byte_d   = sec_byte_q;
        shift_d      = shift_q;
        sd_rd_d      = 1'b0;
        sd_address_d = sd_address_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_FIN);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d       = base_addr;
                    sector_idx_d = 32'd0;
                    word_cnt_d   = '0;
                    byte_idx_d   = 2'd0;
                    sec_byte_d   = '0;
                    shift_d      = 24'd0;
                end
            end
            S_WAIT_RDY: begin
                if (sd_ready_for_read) begin
                    sd_rd_d      = 1'b1;
                    sd_address_d = base_q + sector_idx_q * SECTOR_STEP;
                end
            end
            S_ISSUE: begin
                sd_rd_d = sd_ready_for_read;
            end
            S_RECV: begin
                if (rx_evt_c) begin
                    shift_d    = {shift_q[15:0], sd_byte};
                    byte_idx_d = byte_idx_q + 2'd1;
                    sec_byte_d = sector_end_c ? '0 : sec_byte_q + SEC_W'(1);
                    if (word_wr_c) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_cnt_q[ADDR_W-1:0];
                        wr_data_d  = {shift_q, sd_byte};
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                    if (sector_end_c && frame_more_c) begin
                        sector_idx_d = sector_idx_q + 32'd1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q       <= 32'd0;
            sector_idx_q <= 32'd0;
            word_cnt_q   <= '0;
            byte_idx_q   <= 2'd0;
            sec_byte_q   <= '0;
            shift_q      <= 24'd0;
            avail_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sd_rd_q      <= 1'b0;
            sd_address_q <= 32'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 32'd0;
        end else begin
            base_q       <= base_d;
            sector_idx_q <= sector_idx_d;
            word_cnt_q   <= word_cnt_d;
            byte_idx_q   <= byte_idx_d;
            sec_byte_q   <= sec_byte_d;
            shift_q      <= shift_d;
            avail_q      <= sd_byte_available;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sd_rd_q      <= sd_rd_d;
            sd_address_q <= sd_address_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign sd_rd      = sd_rd_q;
    assign sd_address = sd_address_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_sd_frame_fetch.sv
// Scoreboard bench for sd_frame_fetch: two instances (full-sector and
// partial-sector frame sizes) share one SD controller model.
module tb_sd_frame_fetch;

    localparam int unsigned SECTOR  = 512;
    localparam int unsigned AW      = 17;
    localparam int unsigned WORDS_A = 256;
    localparam int unsigned WORDS_B = 130;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic [31:0] base_addr;
    logic        mdl_ready, hold_rdy;
    logic [7:0]  sd_byte;
    logic        sd_byte_available;
    logic        sd_ready_for_read;
    logic        sel;

    logic          a_busy, a_done, a_sd_rd, a_wr_en;
    logic [31:0]   a_sd_address, a_wr_data;
    logic [AW-1:0] a_wr_addr;
    logic          b_busy, b_done, b_sd_rd, b_wr_en;
    logic [31:0]   b_sd_address, b_wr_data;
    logic [AW-1:0] b_wr_addr;

    logic          m_busy, m_done, m_sd_rd, m_wr_en;
    logic [31:0]   m_sd_address, m_wr_data;
    logic [AW-1:0] m_wr_addr;

    wr_t         wq[$];
    logic [31:0] aq[$];
    int          errs = 0;
    int          checks = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          wr_base = 0;
    int          done_base = 0;
    int          mdl_hi_first = 1;
    bit          mdl_busy = 0;

    assign sd_ready_for_read = mdl_ready & ~hold_rdy;
    assign m_busy       = sel ? b_busy       : a_busy;
    assign m_done       = sel ? b_done       : a_done;
    assign m_sd_rd      = sel ? b_sd_rd      : a_sd_rd;
    assign m_sd_address = sel ? b_sd_address : a_sd_address;
    assign m_wr_en      = sel ? b_wr_en      : a_wr_en;
    assign m_wr_addr    = sel ? b_wr_addr    : a_wr_addr;
    assign m_wr_data    = sel ? b_wr_data    : a_wr_data;

    sd_frame_fetch #(.WORDS(WORDS_A), .SECTOR_BYTES(SECTOR), .ADDR_W(AW)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_addr),
        .busy(a_busy), .done(a_done), .sd_rd(a_sd_rd), .sd_address(a_sd_address),
        .sd_ready_for_read(sd_ready_for_read), .sd_byte(sd_byte),
        .sd_byte_available(sd_byte_available),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
    );

    sd_frame_fetch #(.WORDS(WORDS_B), .SECTOR_BYTES(SECTOR), .ADDR_W(AW)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_addr),
        .busy(b_busy), .done(b_done), .sd_rd(b_sd_rd), .sd_address(b_sd_address),
        .sd_ready_for_read(sd_ready_for_read), .sd_byte(sd_byte),
        .sd_byte_available(sd_byte_available),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // SD controller: 3 busy cycles after accepting sd_rd, then one sector of
    // bytes 0x00..0xFF repeating, each byte a fresh rising edge of available.
    initial begin : sd_model
        logic [7:0] bv;
        bv = 8'd0;
        mdl_ready = 1'b1;
        sd_byte = 8'd0;
        sd_byte_available = 1'b0;
        forever begin
            @(negedge clk);
            if (m_sd_rd && sd_ready_for_read) begin
                mdl_busy = 1'b1;
                @(posedge clk);
                #1 mdl_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                for (int i = 0; i < int'(SECTOR); i++) begin
                    sd_byte = bv;
                    bv = bv + 8'd1;
                    sd_byte_available = 1'b1;
                    repeat ((i == 0) ? mdl_hi_first : 1) @(posedge clk);
                    #1 sd_byte_available = 1'b0;
                    @(posedge clk);
                    #1;
                end
                mdl_ready = 1'b1;
                mdl_busy = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic        rd_prev;
        logic [31:0] addr_hold;
        wr_t         e;
        rd_prev = 1'b0;
        addr_hold = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_prev = 1'b0;
            end else begin
                if (m_wr_en) begin
                    wr_cnt++;
                    if (wq.size() == 0) begin
                        chk("wr_unexpected", 32'(m_wr_addr), ~32'(m_wr_addr));
                    end else begin
                        e = wq.pop_front();
                        chk("wr_addr", 32'(m_wr_addr), 32'(e.addr));
                        chk("wr_data", m_wr_data, e.data);
                    end
                end
                if (m_sd_rd && !rd_prev) begin
                    if (aq.size() == 0) begin
                        chk("rd_unexpected", m_sd_address, ~m_sd_address);
                    end else begin
                        chk("sd_address", m_sd_address, aq.pop_front());
                    end
                    addr_hold = m_sd_address;
                end else if (m_sd_rd) begin
                    chk("sd_address_stable", m_sd_address, addr_hold);
                end
                if (m_done) done_cnt++;
                rd_prev = m_sd_rd;
            end
        end
    end

    task automatic start_frame(input logic which, input logic [31:0] base, input int words);
        wr_t        e;
        logic [7:0] b;
        int         sectors;
        sel = which;
        sectors = (words * 4 + int'(SECTOR) - 1) / int'(SECTOR);
        for (int s = 0; s < sectors; s++) aq.push_back(base + 32'(s * int'(SECTOR)));
        for (int n = 0; n < words; n++) begin
            b = 8'(n * 4);
            e.addr = AW'(n);
            e.data = {b, b + 8'd1, b + 8'd2, b + 8'd3};
            wq.push_back(e);
        end
        @(posedge clk);
        #1;
        wr_base = wr_cnt;
        done_base = done_cnt;
        base_addr = base;
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        base_addr = 32'hA5A5_A5A5;
    endtask

    task automatic finish_frame(input int words);
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (m_done) break;
        end
        chk("done_seen", 32'(m_done), 32'd1);
        chk("busy_at_done", 32'(m_busy), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(m_done), 32'd0);
        chk("busy_after_done", 32'(m_busy), 32'd0);
        chk("wr_sb_empty", 32'(wq.size()), 32'd0);
        chk("rd_sb_empty", 32'(aq.size()), 32'd0);
        chk("done_count", 32'(done_cnt - done_base), 32'd1);
        chk("write_count", 32'(wr_cnt - wr_base), 32'(words));
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 4000; i++) begin
            if (wr_cnt - wr_base >= n) break;
            @(posedge clk);
        end
        chk("words_reached", 32'(wr_cnt - wr_base >= n), 32'd1);
    endtask

    task automatic check_outputs_zero();
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_done", 32'(m_done), 32'd0);
        chk("rst_sd_rd", 32'(m_sd_rd), 32'd0);
        chk("rst_sd_address", m_sd_address, 32'd0);
        chk("rst_wr_en", 32'(m_wr_en), 32'd0);
        chk("rst_wr_addr", 32'(m_wr_addr), 32'd0);
        chk("rst_wr_data", m_wr_data, 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        base_addr = 32'd0;
        hold_rdy = 1'b0;
        sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic two-sector frame.
        start_frame(1'b0, 32'h0000_1000, int'(WORDS_A));
        finish_frame(int'(WORDS_A));

        // Partial final sector, with the second sector address wrapping past 2^32.
        start_frame(1'b1, 32'hFFFF_FE00, int'(WORDS_B));
        finish_frame(int'(WORDS_B));

        // Controller not ready for 50 cycles.
        hold_rdy = 1'b1;
        start_frame(1'b0, 32'h0004_0000, int'(WORDS_A));
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("hold_sd_rd", 32'(m_sd_rd), 32'd0);
            chk("hold_busy", 32'(m_busy), 32'd1);
        end
        @(posedge clk);
        #1 hold_rdy = 1'b0;
        finish_frame(int'(WORDS_A));

        // First byte of each sector has available held high for 10 cycles.
        mdl_hi_first = 10;
        start_frame(1'b1, 32'h0000_2000, int'(WORDS_B));
        finish_frame(int'(WORDS_B));
        mdl_hi_first = 1;

        // Reset after 100 words, then a fresh frame must restart at word 0.
        start_frame(1'b0, 32'h0010_0000, int'(WORDS_A));
        wait_words(100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero();
        wq.delete();
        aq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!mdl_busy) break;
            @(posedge clk);
        end
        start_frame(1'b0, 32'h0010_0000, int'(WORDS_A));
        finish_frame(int'(WORDS_A));

        // A second start during the fetch is ignored.
        start_frame(1'b0, 32'h0000_8000, int'(WORDS_A));
        wait_words(40);
        @(posedge clk);
        #1;
        base_addr = 32'h0BAD_0000;
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        finish_frame(int'(WORDS_A));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sd_frame_fetch.md
SD_FRAME_FETCH -- requirements
Module: sd_frame_fetch

Interface
REQ-001 SHALL have parameter WORDS, default 19200, meaning the number of 32-bit words fetched per frame (76800 bytes).
REQ-002 SHALL have parameter SECTOR_BYTES, default 512, meaning the bytes delivered by the SD controller per read command.
REQ-003 SHALL have parameter ADDR_W, default 17, meaning the frame-buffer word-address width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports listed below.
REQ-005 clk  in  1  single clock; shared with the SD controller and the frame-buffer write port.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle request to fetch one frame.
REQ-008 base_addr  in  32  SD byte address of the first sector; sampled on an accepted start.
REQ-009 busy  out  1  high from the accepted start until done.
REQ-010 done  out  1  one-cycle pulse when the last word has been written.
REQ-011 sd_rd  out  1  read request to the SD controller.
REQ-012 sd_address  out  32  byte address of the requested sector.
REQ-013 sd_ready_for_read  in  1  the controller is idle and accepts sd_rd.
REQ-014 sd_byte  in  8  data byte from the controller.
REQ-015 sd_byte_available  in  1  level signal; each rising edge presents one new sd_byte.
REQ-016 wr_en  out  1  one-cycle frame-buffer write strobe.
REQ-017 wr_addr  out  ADDR_W  frame-buffer word address.
REQ-018 wr_data  out  32  packed word.

Function
REQ-019 The FSM SHALL have the states IDLE, WAIT_RDY, ISSUE, RECV and FIN.
REQ-020 IDLE: start=1 SHALL latch base_addr, clear the word, byte and sector counters, and go to WAIT_RDY; in all other states start SHALL be ignored.
REQ-021 WAIT_RDY: sd_ready_for_read=1 SHALL drive sd_address = latched_base + sector_idx*SECTOR_BYTES, assert sd_rd and go to ISSUE.
REQ-022 ISSUE: sd_rd SHALL be held high until sd_ready_for_read=0 is sampled, then sd_rd SHALL drop in the next cycle and the FSM SHALL go to RECV.
REQ-023 sd_address SHALL remain stable for the whole time sd_rd is high.
REQ-024 A byte event is one cycle where sd_byte_available=1 and its registered previous value was 0; sd_byte SHALL be captured in that cycle.
REQ-025 Byte packing SHALL be big-endian: the first byte goes to [31:24] and the fourth byte to [7:0].
REQ-026 When the fourth byte is captured and fewer than WORDS words have been written, wr_en SHALL pulse in the next cycle with wr_addr equal to the word count, and the word count SHALL then increment.
REQ-027 RECV SHALL count exactly SECTOR_BYTES byte events per sector.
REQ-028 On the last byte of a sector, the FSM SHALL go to WAIT_RDY with sector_idx+1 if the word count is below WORDS, else to FIN.
REQ-029 If WORDS*4 is not a multiple of SECTOR_BYTES, the excess bytes of the final sector SHALL be consumed but produce no wr_en.
REQ-030 FIN: done SHALL be 1 for one cycle, busy SHALL be 0 in the next cycle, and the FSM SHALL return to IDLE.
REQ-031 busy SHALL be 1 in WAIT_RDY, ISSUE, RECV and FIN, and 0 in IDLE.
REQ-032 A byte event outside RECV SHALL be ignored.
REQ-033 A byte event in the same cycle as the RECV->WAIT_RDY transition SHALL NOT occur per protocol; if it does occur, it SHALL be dropped.
REQ-034 The word counter SHALL be ADDR_W+1 bits wide, so that WORDS never wraps it.
REQ-035 wr_addr SHALL never exceed WORDS-1.
REQ-036 The sector address SHALL be computed modulo 2^32.

Reset
REQ-037 rst_n=0 SHALL immediately force IDLE with busy=0, done=0, sd_rd=0, sd_address=0, wr_en=0, wr_addr=0, wr_data=0, all counters 0 and the edge register 0.
REQ-038 A reset in the middle of a fetch SHALL abandon the frame, and a later start SHALL restart from word 0.
REQ-039 The first start SHALL be accepted no earlier than the first clock edge after rst_n rises.

Verification
REQ-040 Scenario (basic): WORDS=256, base_addr=0x1000, controller model with 3-cycle busy and bytes 0x00..0xFF repeating -> sd_address 0x1000 then 0x1200; 256 wr_en pulses; word 0 = 0x00010203; done is a single pulse.
REQ-041 Scenario (partial sector): WORDS=130 -> two sectors are read; the second sector's bytes 8..511 produce no wr_en; last wr_addr=129.
REQ-042 Scenario (handshake): sd_ready_for_read held 0 for 50 cycles after start -> sd_rd stays 0 and busy=1; after it rises, sd_rd is held until ready drops and sd_address is stable throughout.
REQ-043 Scenario (byte_available level): sd_byte_available held high for 10 cycles -> exactly one byte captured.
REQ-044 Scenario (reset mid-fetch): rst_n pulsed low after 100 words, then start -> all outputs 0 during reset; the next wr_addr sequence starts at 0.
REQ-045 Scenario (start while busy): a second start issued at word 40 -> it is ignored; exactly WORDS writes occur and one done pulse.
